vga_timing_gen: RTL and testbench

//  Generates the 640x480@60Hz VGA raster timing that drives the board's VGA DAC
//  (VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK) from the 50 MHz system clock.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/pixel_tick_gen.sv | 40 ++++
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants, coordinate type and visibility helper
// for the raster timing generator and the colour generator.
package vga_timing_pkg;

  localparam int unsigned H_VIS  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

  function automatic logic is_visible(coord_t x, coord_t y,
                                      int unsigned h_vis = H_VIS,
                                      int unsigned v_vis = V_VIS);
    return (32'(x) < h_vis) && (32'(y) < v_vis);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: driven by the timing generator, consumed by the
// colour generator and the VGA DAC pins.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   blank_n;
  logic   sync_n;
  logic   vga_clk;
  logic   pix_en;
  coord_t x;
  coord_t y;
  logic   frame_start;

  modport master (
    output hsync, vsync, blank_n, sync_n, vga_clk, pix_en, x, y, frame_start
  );

  modport slave (
    input hsync, vsync, blank_n, sync_n, vga_clk, pix_en, x, y, frame_start
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divides the system clock by CLK_DIV into a one-clock pixel strobe and a
// registered 50% duty pixel clock for the DAC.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic vga_clk
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] Half = CntW'(CLK_DIV / 2);

  logic [CntW-1:0] div_q, div_d;
  logic            pix_en_q;
  logic            vga_clk_q;

  always_comb begin
    div_d = (div_q == Last) ? '0 : div_q + CntW'(1);
  end

  // Strobe and clock are decoded from the next count so they line up with div_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pix_en_q  <= (div_d == Last);
      vga_clk_q <= (div_d >= Half);
    end
  end

  assign pix_en  = pix_en_q;
  assign vga_clk = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered sync, blank and
// frame-start decode, all aligned with the presented x/y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = vga_timing_pkg::H_VIS,
  parameter int unsigned H_FP    = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP    = vga_timing_pkg::H_BP,
  parameter int unsigned V_VIS   = vga_timing_pkg::V_VIS,
  parameter int unsigned V_FP    = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP    = vga_timing_pkg::V_BP
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;

  localparam coord_t HLast   = coord_t'(HTot - 1);
  localparam coord_t VLast   = coord_t'(VTot - 1);
  localparam coord_t HsStart = coord_t'(H_VIS + H_FP);
  localparam coord_t HsEnd   = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VsStart = coord_t'(V_VIS + V_FP);
  localparam coord_t VsEnd   = coord_t'(V_VIS + V_FP + V_SYNC);

  logic   pix_en;
  logic   vga_clk;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   frame_start_q, frame_start_d;
  logic   hsync_q, vsync_q, blank_n_q;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .vga_clk(vga_clk)
  );

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (x_q == HLast) begin
        x_d = '0;
        if (y_q == VLast) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + coord_t'(1);
        end
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
  end

  // Decode from next-state so sync/blank never lag the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= !((x_d >= HsStart) && (x_d < HsEnd));
      vsync_q       <= !((y_d >= VsStart) && (y_d < VsEnd));
      blank_n_q     <= is_visible(x_d, y_d, H_VIS, V_VIS);
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank_n     = blank_n_q;
  assign vga.sync_n      = 1'b0;
  assign vga.pix_en      = pix_en;
  assign vga.vga_clk     = vga_clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, CLK_DIV=4 and a tiny-raster instance checked
// every cycle against an arithmetic model of clocks elapsed since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       vga_clk;
    logic       pix_en;
    logic       frame_start;
    logic [9:0] x;
    logic [9:0] y;
  } out_t;

  typedef struct {
    int d, hv, hf, hs, hb, vv, vf, vs, vb;
  } cfg_t;

  typedef struct {
    int   k;
    int   x;
    int   y;
    logic hs;
    logic bl;
    logic pe;
  } vec_t;

  logic clk;
  logic rst;
  int   k;
  int   checks;
  int   errors;
  cfg_t cfg_a, cfg_b, cfg_c;
  vec_t tbl[11];
  int   ti;

  int a_hs, a_hs_first, a_bl, a_l1, a_l2, a_pe, a_vc;
  int c_hs, c_pe, c_vc, c_l1;
  int b_vs, b_fs1, b_fs2, b_fs_n;

  vga_timing_gen_if ia ();
  vga_timing_gen_if ib ();
  vga_timing_gen_if ic ();

  vga_timing_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .reset(rst), .vga(ia));

  vga_timing_gen #(
    .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (.clk(clk), .reset(rst), .vga(ib));

  vga_timing_gen #(.CLK_DIV(4)) dut_c (.clk(clk), .reset(rst), .vga(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after kk clock edges since reset release.
  function automatic out_t model(cfg_t c, int kk, logic in_rst);
    out_t o;
    int ht, vt, n, dv, px, ln;
    o       = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    if (in_rst || kk == 0) return o;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    n  = kk / c.d;
    dv = kk % c.d;
    px = n % ht;
    ln = (n / ht) % vt;
    o.x           = 10'(px);
    o.y           = 10'(ln);
    o.hsync       = !(px >= c.hv + c.hf && px < c.hv + c.hf + c.hs);
    o.vsync       = !(ln >= c.vv + c.vf && ln < c.vv + c.vf + c.vs);
    o.blank_n     = (px < c.hv) && (ln < c.vv);
    o.sync_n      = 1'b0;
    o.vga_clk     = (dv >= c.d / 2);
    o.pix_en      = (dv == c.d - 1);
    o.frame_start = (dv == 0) && (n > 0) && (n % (ht * vt) == 0);
    return o;
  endfunction

  function automatic string show(out_t o);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b bl=%b sn=%b vc=%b pe=%b fs=%b", o.x, o.y,
                     o.hsync, o.vsync, o.blank_n, o.sync_n, o.vga_clk, o.pix_en,
                     o.frame_start);
  endfunction

  task automatic check_out(string name, out_t got, out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %s expected %s", name, k, show(got), show(exp));
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic scoreboard();
    out_t g;
    g = {ia.hsync, ia.vsync, ia.blank_n, ia.sync_n, ia.vga_clk, ia.pix_en, ia.frame_start,
         ia.x, ia.y};
    check_out("dut_a", g, model(cfg_a, k, rst));
    g = {ib.hsync, ib.vsync, ib.blank_n, ib.sync_n, ib.vga_clk, ib.pix_en, ib.frame_start,
         ib.x, ib.y};
    check_out("dut_b", g, model(cfg_b, k, rst));
    g = {ic.hsync, ic.vsync, ic.blank_n, ic.sync_n, ic.vga_clk, ic.pix_en, ic.frame_start,
         ic.x, ic.y};
    check_out("dut_c", g, model(cfg_c, k, rst));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) k++;
    @(negedge clk);
    scoreboard();
  endtask

  // Asynchronous reset asserted mid-cycle, held for hold edges, released at a negedge.
  task automatic pulse_reset(int hold);
    @(posedge clk);
    #(1 + $urandom_range(0, 2));
    rst = 1'b1;
    k   = 0;
    #1;
    scoreboard();
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    k      = 0;
    checks = 0;
    errors = 0;
    cfg_a  = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg_b  = '{2, 8, 2, 3, 2, 6, 2, 2, 3};
    cfg_c  = '{4, 640, 16, 96, 48, 480, 10, 2, 33};

    // {k, x, y, hsync, blank_n, pix_en} for the default instance
    tbl[0]  = '{1,    0,   0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,    1,   0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1278, 639, 0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1280, 640, 0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1311, 655, 0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1312, 656, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1503, 751, 0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1504, 752, 0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1599, 799, 0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1600, 0,   1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{3200, 0,   2, 1'b1, 1'b1, 1'b0};

    a_hs = 0; a_hs_first = -1; a_bl = 0; a_l1 = -1; a_l2 = -1; a_pe = 0; a_vc = 0;
    c_hs = 0; c_pe = 0; c_vc = 0; c_l1 = -1;
    b_vs = 0; b_fs1 = -1; b_fs2 = -1; b_fs_n = 0;
    ti = 0;

    repeat (3) tick();
    check_int("reset_x", int'(ia.x), 0);
    check_int("reset_hsync", int'(ia.hsync), 1);
    rst = 1'b0;

    while (k < 3300) begin
      tick();
      if (ti < 11 && k == tbl[ti].k) begin
        checks++;
        if (int'(ia.x) != tbl[ti].x || int'(ia.y) != tbl[ti].y || ia.hsync !== tbl[ti].hs ||
            ia.blank_n !== tbl[ti].bl || ia.pix_en !== tbl[ti].pe) begin
          errors++;
          $display("FAIL vec%0d k=%0d got x=%0d y=%0d hs=%b bl=%b pe=%b expected x=%0d y=%0d hs=%b bl=%b pe=%b",
                   ti, k, ia.x, ia.y, ia.hsync, ia.blank_n, ia.pix_en,
                   tbl[ti].x, tbl[ti].y, tbl[ti].hs, tbl[ti].bl, tbl[ti].pe);
        end
        ti++;
      end
      if (k >= 1600 && k < 3200) begin
        if (!ia.hsync) a_hs++;
        if (ia.blank_n) a_bl++;
        if (!ia.hsync && a_hs_first < 0) a_hs_first = k - 1600;
      end
      if (ia.x == 0 && ia.y == 1 && a_l1 < 0) a_l1 = k;
      if (ia.x == 0 && ia.y == 2 && a_l2 < 0) a_l2 = k;
      if (k <= 3200) begin
        if (ia.pix_en) a_pe++;
        if (ia.vga_clk) a_vc++;
        if (!ic.hsync) c_hs++;
        if (ic.pix_en) c_pe++;
        if (ic.vga_clk) c_vc++;
      end
      if (ic.y == 1 && c_l1 < 0) c_l1 = k;
      if (k <= 390 && !ib.vsync) b_vs++;
      if (ib.frame_start) begin
        b_fs_n++;
        if (b_fs1 < 0) b_fs1 = k;
        else if (b_fs2 < 0) b_fs2 = k;
      end
    end

    check_int("table_entries_reached", ti, 11);
    check_int("a_hsync_width", a_hs, 192);
    check_int("a_hsync_start", a_hs_first, 1312);
    check_int("a_blank_width", a_bl, 1280);
    check_int("a_line_period", a_l2 - a_l1, 1600);
    check_int("a_pix_en_count", a_pe, 1600);
    check_int("a_vga_clk_high", a_vc, 1600);
    check_int("c_hsync_width", c_hs, 384);
    check_int("c_pix_en_count", c_pe, 800);
    check_int("c_vga_clk_high", c_vc, 1600);
    check_int("c_line_period", c_l1, 3200);
    check_int("b_vsync_width", b_vs, 60);
    check_int("b_first_frame_start", b_fs1, 390);
    check_int("b_frame_period", b_fs2 - b_fs1, 390);
    check_int("b_frame_start_count", b_fs_n, 8);

    // Random-length runs interrupted by asynchronous resets of random length.
    repeat (6) begin
      repeat ($urandom_range(50, 2500)) tick();
      pulse_reset($urandom_range(1, 3));
    end
    repeat (200) tick();

    // One-clock reset mid-frame: x=1 must appear two clocks after release.
    repeat (777) tick();
    pulse_reset(1);
    tick();
    check_int("first_pix_en_after_reset", int'(ia.pix_en), 1);
    check_int("x_zero_after_reset", int'(ia.x), 0);
    tick();
    check_int("x_one_after_reset", int'(ia.x), 1);
    check_int("y_zero_after_reset", int'(ia.y), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
